// File: rtl/double_buffer_unpacker_pkg.sv
// Shared types and sizing helpers for the double-buffer word unpacker.
// Queue states are plain localparam codes so legacy blocks can compare against them directly.
package double_buffer_unpacker_pkg;

    typedef logic [1:0] qstate_t;

    localparam qstate_t QS_EMPTY = 2'd0;
    localparam qstate_t QS_HALF  = 2'd1;
    localparam qstate_t QS_FULL  = 2'd2;

    function automatic int unsigned lane_ratio(input int unsigned in_dw,
                                               input int unsigned out_dw);
        return in_dw / out_dw;
    endfunction

    function automatic int unsigned lane_idx_w(input int unsigned in_dw,
                                               input int unsigned out_dw);
        return $clog2(in_dw / out_dw);
    endfunction

endpackage

// File: rtl/word_queue2.sv
// Two-entry word FIFO with registered count and no bypass: a pushed word becomes
// visible on head_o only after the clock edge that writes it.
module word_queue2
    import double_buffer_unpacker_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    qstate_t       count_q;
    qstate_t       count_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q != QS_FULL);
    assign pop_ok  = pop_i && (count_q != QS_EMPTY);

    always_comb begin
        count_d = count_q;
        case (count_q)
            QS_EMPTY: if (push_ok) count_d = QS_HALF;
            QS_HALF: begin
                if (push_ok && !pop_ok) count_d = QS_FULL;
                else if (pop_ok && !push_ok) count_d = QS_EMPTY;
            end
            QS_FULL:  if (pop_ok) count_d = QS_HALF;
            default:  count_d = QS_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= QS_EMPTY;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/double_buffer_unpacker.sv
// Serialises full-width words from the AXI write slave into OUT_DW lanes with frame marking.
// Define UNPACKER_MSB_FIRST_EN to emit the most significant lane of each word first.
module double_buffer_unpacker
    import double_buffer_unpacker_pkg::*;
#(
    parameter int unsigned IN_DW       = 64,
    parameter int unsigned OUT_DW      = 16,
    parameter int unsigned FRAME_LANES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [IN_DW-1:0]  data_i,
    output logic              stall_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [OUT_DW-1:0] m_data_o,
    output logic              m_last_o,
    output logic              frame_done_o,
    output logic [1:0]        occupancy_o,
    output logic              overflow_o
);

    localparam int unsigned RATIO = lane_ratio(IN_DW, OUT_DW);
    localparam int unsigned LW    = lane_idx_w(IN_DW, OUT_DW);
    localparam int unsigned FW    = $clog2(FRAME_LANES);

    localparam logic [LW-1:0] LANE_LAST  = LW'(RATIO - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LANES - 1);

    if ((IN_DW % OUT_DW) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("IN_DW/OUT_DW must be a power of 2 and at least 2");
    end
    if (FRAME_LANES < 2) begin : g_bad_frame
        $error("FRAME_LANES must be at least 2");
    end

    logic [IN_DW-1:0] head;
    logic [1:0]       count;
    logic             accept;
    logic             xfer;
    logic             pop;
    logic [LW-1:0]    lane_idx_q;
    logic [LW-1:0]    lane_sel;
    logic [FW-1:0]    frame_cnt_q;
    logic             frame_done_q;
    logic             overflow_q;

    word_queue2 #(
        .DW (IN_DW)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (data_i),
        .head_o  (head),
        .count_o (count)
    );

    // Slave derives pushing_o from stall_i combinationally, so stall must come from registers only.
    assign stall_o   = (count == QS_FULL);
    assign m_valid_o = (count != QS_EMPTY);
    assign accept    = push_i && !stall_o;
    assign xfer      = m_valid_o && m_ready_i;
    assign pop       = xfer && (lane_idx_q == LANE_LAST);

`ifdef UNPACKER_MSB_FIRST_EN
    assign lane_sel = LANE_LAST - lane_idx_q;
`else
    assign lane_sel = lane_idx_q;
`endif

    assign m_data_o     = m_valid_o ? head[OUT_DW*lane_sel +: OUT_DW] : '0;
    assign m_last_o     = m_valid_o && (frame_cnt_q == FRAME_LAST);
    assign frame_done_o = frame_done_q;
    assign occupancy_o  = count;
    assign overflow_o   = overflow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_idx_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= xfer && m_last_o;
            if (push_i && stall_o) overflow_q <= 1'b1;
            if (xfer) begin
                lane_idx_q  <= (lane_idx_q == LANE_LAST) ? '0 : lane_idx_q + 1'b1;
                frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_double_buffer_unpacker.sv
// Randomised scoreboard bench for double_buffer_unpacker (FRAME_LANES=6 so frames straddle words).
module tb_double_buffer_unpacker;

    localparam int unsigned IN_DW       = 64;
    localparam int unsigned OUT_DW      = 16;
    localparam int unsigned FRAME_LANES = 6;
    localparam int unsigned RATIO       = IN_DW / OUT_DW;

    typedef struct {
        logic [OUT_DW-1:0] data;
        logic              last;
    } lane_t;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              push_i = 1'b0;
    logic [IN_DW-1:0]  data_i = '0;
    logic              stall_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;
    logic [OUT_DW-1:0] m_data_o;
    logic              m_last_o;
    logic              frame_done_o;
    logic [1:0]        occupancy_o;
    logic              overflow_o;

    double_buffer_unpacker #(
        .IN_DW       (IN_DW),
        .OUT_DW      (OUT_DW),
        .FRAME_LANES (FRAME_LANES)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .push_i       (push_i),
        .data_i       (data_i),
        .stall_o      (stall_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .frame_done_o (frame_done_o),
        .occupancy_o  (occupancy_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: word count, sticky error, expected lanes in transfer order.
    lane_t             exp_q[$];
    int                mdl_words = 0;
    bit                mdl_ovf = 0;
    int                enq_lanes = 0;
    int                xfer_cnt = 0;
    bit                fd_exp = 0;
    bit                pend_accept = 0;
    bit                pend_ovf = 0;
    bit                hold_pending = 0;
    logic [OUT_DW-1:0] hold_data;
    logic              hold_last;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model, then advances the model over the next edge.
    always @(negedge clk) begin
        lane_t e;
        if (rst_i) begin
            exp_q.delete();
            mdl_words    = 0;
            mdl_ovf      = 0;
            enq_lanes    = 0;
            xfer_cnt     = 0;
            fd_exp       = 0;
            pend_accept  = 0;
            pend_ovf     = 0;
            hold_pending = 0;
        end else begin
            check("valid", m_valid_o, mdl_words != 0);
            check("stall", stall_o, mdl_words == 2);
            check("occupancy", occupancy_o, mdl_words);
            check("overflow", overflow_o, mdl_ovf);
            check("frame_done", frame_done_o, fd_exp);
            if (mdl_words == 0) begin
                check("idle_data", m_data_o, 0);
                check("idle_last", m_last_o, 0);
            end
            if (hold_pending) begin
                check("hold_data", m_data_o, hold_data);
                check("hold_last", m_last_o, hold_last);
            end
            hold_pending = (mdl_words != 0) && !m_ready_i;
            hold_data    = m_data_o;
            hold_last    = m_last_o;
            fd_exp       = 0;
            if (mdl_words != 0 && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("lane_data", m_data_o, e.data);
                    check("lane_last", m_last_o, e.last);
                    fd_exp = e.last;
                end
                xfer_cnt++;
                if (xfer_cnt % RATIO == 0) mdl_words--;
            end
            if (pend_accept) mdl_words++;
            if (pend_ovf) mdl_ovf = 1;
            pend_accept = 0;
            pend_ovf    = 0;
        end
    end

    // One cycle of stimulus, called just after a rising edge.
    task automatic step(input logic push, input logic [IN_DW-1:0] d, input logic rdy);
        lane_t l;
        int    idx;
        push_i    = push;
        data_i    = d;
        m_ready_i = rdy;
        if (push) begin
            if (mdl_words < 2) begin
                pend_accept = 1;
                for (int i = 0; i < RATIO; i++) begin
`ifdef UNPACKER_MSB_FIRST_EN
                    idx = RATIO - 1 - i;
`else
                    idx = i;
`endif
                    l.data = d[OUT_DW*idx +: OUT_DW];
                    l.last = (enq_lanes % FRAME_LANES) == FRAME_LANES - 1;
                    enq_lanes++;
                    exp_q.push_back(l);
                end
            end else begin
                pend_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        push_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(2, 1'b1);

        // Single word, ready held high
        step(1'b1, 64'h0004_0003_0002_0001, 1'b1);
        idle(6, 1'b1);

        // Three back-to-back pushes under backpressure, then release
        step(1'b1, 64'h1111_2222_3333_4444, 1'b0);
        step(1'b1, 64'h5555_6666_7777_8888, 1'b0);
        step(1'b1, 64'hdead_beef_dead_beef, 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Ready toggling every cycle
        step(1'b1, 64'ha1a2_a3a4_a5a6_a7a8, 1'b0);
        step(1'b1, 64'hb1b2_b3b4_b5b6_b7b8, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1);
        end

        // Reset mid-word, then a fresh word starting at lane 0 and frame position 0
        step(1'b1, 64'hc004_c003_c002_c001, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        idle(1, 1'b0);
        step(1'b1, 64'hd004_d003_d002_d001, 1'b1);
        idle(6, 1'b1);

        // Frame boundaries across three words
        do_reset();
        step(1'b1, 64'h0104_0103_0102_0101, 1'b1);
        step(1'b1, 64'h0204_0203_0202_0201, 1'b1);
        idle(4, 1'b1);
        step(1'b1, 64'h0304_0303_0302_0301, 1'b1);
        idle(10, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
        idle(20, 1'b1);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
